// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between fetch_unit (master) and the memory (slave).
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_re;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_re, output imem_addr, input  imem_rdata);
    modport slave  (input  imem_re, input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads, buffers up to two {insn, pc} entries for decode.
// Optional FETCH_PERF_EN adds perf_fetch / perf_flush / perf_stall counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    fetch_unit_if.master imem,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        insn_valid,
    output logic        run_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CNT_W    = 3;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] pc;
    } qent_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    qent_t           q0, q1;
    logic            v0, v1;
    logic            resp_v;
    logic [XLEN-1:0] resp_pc;
    logic            run_q;

    qent_t           q0_n, q1_n, new_ent;
    logic            v0_n, v1_n;
    logic            pop_c;
    logic            issue_c;
    logic [1:0]      occ_c;
    logic [XLEN-1:0] fetch_pc_n;

    // A pop this cycle frees a slot for the read issued now, which lands one cycle later.
    assign pop_c   = v0 & ~stall;
    assign occ_c   = 2'(v0) + 2'(v1);
    assign issue_c = (state == FETCH) & ~redirect_en &
                     ((CNT_W'(occ_c) + CNT_W'(resp_v)) < (CNT_W'(2) + CNT_W'(pop_c)));

    assign imem.imem_re   = issue_c;
    assign imem.imem_addr = fetch_pc;

    assign insn       = q0.insn;
    assign pc         = q0.pc;
    assign insn_valid = v0;
    assign run_out    = run_q;

    // Queue next state: redirect flushes everything, else pop then push the returning read.
    always_comb begin
        q0_n    = q0;
        q1_n    = q1;
        v0_n    = v0;
        v1_n    = v1;
        new_ent = '{insn: imem.imem_rdata, pc: resp_pc};
        if (redirect_en) begin
            v0_n = 1'b0;
            v1_n = 1'b0;
        end else begin
            if (pop_c) begin
                q0_n = q1;
                v0_n = v1;
                v1_n = 1'b0;
            end
            if (resp_v) begin
                if (!v0_n) begin
                    q0_n = new_ent;
                    v0_n = 1'b1;
                end else begin
                    q1_n = new_ent;
                    v1_n = 1'b1;
                end
            end
        end
        if (!v0_n) q0_n = '{insn: NOP_INSN, pc: '0};
        if (!v1_n) q1_n = '{insn: NOP_INSN, pc: '0};
    end

    always_comb begin
        fetch_pc_n = fetch_pc;
        if (redirect_en)  fetch_pc_n = redirect_pc & ALIGN_MASK;
        else if (issue_c) fetch_pc_n = fetch_pc + PC_STEP;
    end

    // State, queue and in-flight tracking; a read issued during a redirect is never tracked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            q0       <= '{insn: NOP_INSN, pc: '0};
            q1       <= '{insn: NOP_INSN, pc: '0};
            v0       <= 1'b0;
            v1       <= 1'b0;
            resp_v   <= 1'b0;
            resp_pc  <= '0;
            run_q    <= 1'b0;
        end else begin
            state    <= run ? FETCH : IDLE;
            fetch_pc <= fetch_pc_n;
            q0       <= q0_n;
            q1       <= q1_n;
            v0       <= v0_n;
            v1       <= v1_n;
            resp_v   <= issue_c;
            resp_pc  <= fetch_pc;
            run_q    <= run;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch <= '0;
            perf_flush <= '0;
            perf_stall <= '0;
        end else begin
            perf_fetch <= perf_fetch + XLEN'(issue_c);
            perf_flush <= perf_flush + XLEN'(redirect_en);
            perf_stall <= perf_stall + XLEN'(v0 & stall);
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port run, input, 1: core enable; fetch issues only while high.
REQ-005 SHALL have port stall, input, 1: downstream decoder cannot accept the presented instruction this cycle.
REQ-006 SHALL have port redirect_en, input, 1: taken branch/jal/jalr from execute, one-cycle pulse.
REQ-007 SHALL have port redirect_pc, input, 32: new fetch target, valid with redirect_en.
REQ-008 SHALL have port imem_re, output, 1: instruction memory read request.
REQ-009 SHALL have port imem_addr, output, 32: read address, word aligned.
REQ-010 SHALL have port imem_rdata, input, 32: read data, valid exactly one cycle after imem_re.
REQ-011 SHALL have port insn, output, 32: instruction presented to decode.
REQ-012 SHALL have port pc, output, 32: address of insn.
REQ-013 SHALL have port insn_valid, output, 1: insn/pc hold a real instruction.
REQ-014 SHALL have port run_out, output, 1: run delayed one cycle.

Function
REQ-015 SHALL implement states IDLE and FETCH; IDLE->FETCH when run=1, FETCH->IDLE when run=0.
REQ-016 SHALL hold a 2-entry instruction queue of {insn, pc}; head drives insn/pc, insn_valid=queue not empty.
REQ-017 SHALL in FETCH assert imem_re with imem_addr=fetch_pc only when occupancy plus in-flight reads < 2.
REQ-018 SHALL advance fetch_pc by 4 on each issued read, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-019 SHALL push imem_rdata with its issue address into the queue the cycle it returns.
REQ-020 SHALL pop the head when insn_valid=1 and stall=0; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-021 SHALL never issue a read that would overflow the queue (full: no issue; empty: insn_valid=0, insn=32'h0000_0013).
REQ-022 SHALL, on redirect_en, flush the queue, discard any in-flight response, set fetch_pc={redirect_pc[31:2],2'b00}; next issued address is that pc.
REQ-023 SHALL give redirect_en priority over stall, pop and push in the same cycle.
REQ-024 SHALL on run falling stop issuing, still push an in-flight response, and retain queue contents; redirect while IDLE still updates fetch_pc.
REQ-025 SHALL have latency: run sampled high at edge N -> imem_re during cycle N+1 -> insn_valid=1 at edge N+2.
REQ-026 SHALL drive run_out from a register loaded with run every cycle.

Reset
REQ-027 SHALL on reset low immediately set: state IDLE, fetch_pc=RESET_PC, queue empty, in-flight cleared, insn=32'h0000_0013, pc=0, insn_valid=0, imem_re=0, run_out=0.
REQ-028 SHALL, when reset asserts mid-operation, drop all queued and in-flight instructions; a response arriving after release SHALL be ignored.

Configuration
REQ-029 SHALL with FETCH_PERF_EN defined add 32-bit outputs perf_fetch (reads issued), perf_flush (redirects), perf_stall (cycles insn_valid=1 and stall=1), reset to 0, wrapping.
REQ-030 SHALL without FETCH_PERF_EN omit these ports and counters; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset release, run=1, imem returns addr-as-data -> insn 0,4,8,C at pc 0,4,8,C, one per cycle.
REQ-032 SHALL cover: stall=1 for 5 cycles -> insn/pc frozen, imem_re low once 2 entries held, resume with no loss/duplicate.
REQ-033 SHALL cover: redirect_en with redirect_pc=32'h0000_0103 while queue full -> flush, next imem_addr=32'h0000_0100, stale data never valid.
REQ-034 SHALL cover: RESET_PC=32'hFFFF_FFF8 -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 SHALL cover: reset asserted with one read in flight -> insn_valid=0 after release until new fetch; with FETCH_PERF_EN counters read 0.
